// File: rtl/store_buffer.sv
// In-order store buffer between the D-cache stage and the cache write port.
// Entries drain one at a time through a req/ack handshake, and loads are forwarded from the youngest matching entry.

module sb_entry_match #(
  parameter int WW = 30
) (
  input  logic          vld,
  input  logic [WW-1:0] entry_waddr,
  input  logic [WW-1:0] ld_waddr,
  output logic          hit
);
  assign hit = vld && (entry_waddr == ld_waddr);
endmodule

module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [ADDR_WIDTH-1:0]    st_addr,
  input  logic [DATA_WIDTH-1:0]    st_data,
  output logic                     full,
  input  logic                     ld_valid,
  input  logic [ADDR_WIDTH-1:0]    ld_addr,
  output logic                     sb_hit,
  output logic                     hit_reserve,
  output logic                     fwd_valid,
  output logic [DATA_WIDTH-1:0]    fwd_data,
  output logic                     drain_req,
  output logic [ADDR_WIDTH-1:0]    drain_addr,
  output logic [DATA_WIDTH-1:0]    drain_data,
  input  logic                     drain_ack,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = ADDR_WIDTH - 2;

  typedef struct packed {
    logic [WW-1:0]         waddr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  entry_t [DEPTH-1:0] mem;
  logic   [DEPTH-1:0] vld;
  logic   [DEPTH-1:0] match;
  logic   [PW-1:0]    head, tail, scan_idx, hit_idx;
  logic   [PW:0]      cnt, cnt_nxt;
  logic               hit_any, push, pop;
  state_t             state, state_nxt;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
  assign full  = (cnt == (PW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign push  = st_valid && !full;
  assign pop   = (state == ISSUE) && drain_ack;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + 1'b1;
    else if (pop && !push) cnt_nxt = cnt - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cnt_nxt != '0) state_nxt = ISSUE;
      ISSUE:   if (pop && cnt_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      vld   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + 1'b1;
      end
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit or while draining.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{waddr: st_addr[ADDR_WIDTH-1:2], data: st_data};
  end

  always @(posedge clk) begin
    if (!rst) assert (!(st_valid && full)) else $warning("store_buffer: store dropped while full");
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      sb_entry_match #(.WW(WW)) u_match (
        .vld        (vld[gi]),
        .entry_waddr(mem[gi].waddr),
        .ld_waddr   (ld_addr[ADDR_WIDTH-1:2]),
        .hit        (match[gi])
      );
    end
  endgenerate

  // Walk oldest to youngest; a later (younger) hit overrides an earlier one.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PW'(i);
      if (match[scan_idx]) begin
        hit_any = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  assign sb_hit      = ld_valid && hit_any;
  assign fwd_valid   = sb_hit;
  assign fwd_data    = sb_hit ? mem[hit_idx].data : '0;
  assign hit_reserve = sb_hit && (hit_idx == head) && (state == ISSUE);

  assign drain_req  = (state == ISSUE);
  assign drain_addr = drain_req ? {mem[head].waddr, 2'b00} : '0;
  assign drain_data = drain_req ? mem[head].data : '0;
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic, checked against a queue model of the buffer contents.
`timescale 1ns/1ps
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, ld_valid, drain_ack;
  logic [31:0] st_addr, st_data, ld_addr;
  logic        full, sb_hit, hit_reserve, fwd_valid, drain_req, empty;
  logic [31:0] fwd_data, drain_addr, drain_data;
  logic [2:0]  count;

  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .full(full),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .sb_hit(sb_hit), .hit_reserve(hit_reserve), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
    .drain_req(drain_req), .drain_addr(drain_addr), .drain_data(drain_data), .drain_ack(drain_ack),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t exp_q[$];   // buffer contents, oldest first
  bit   acc_pend;
  ent_t pend;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare every output to the model, pop on a drain handshake.
  int   hit_i;
  ent_t e;
  always @(negedge clk) begin
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(exp_q.size() == 0));
    chk("drain_req", 32'(drain_req), 32'(exp_q.size() != 0));
    chk("drain_addr", drain_addr, (exp_q.size() != 0) ? exp_q[0].addr : 32'h0);
    chk("drain_data", drain_data, (exp_q.size() != 0) ? exp_q[0].data : 32'h0);
    hit_i = -1;
    if (ld_valid)
      for (int i = 0; i < exp_q.size(); i++)
        if (exp_q[i].addr[31:2] == ld_addr[31:2]) hit_i = i;
    chk("sb_hit", 32'(sb_hit), 32'(hit_i >= 0));
    chk("fwd_valid", 32'(fwd_valid), 32'(hit_i >= 0));
    chk("hit_reserve", 32'(hit_reserve), 32'(hit_i == 0));
    chk("fwd_data", fwd_data, (hit_i >= 0) ? exp_q[hit_i].data : 32'h0);
    acc_pend = !rst && st_valid && (exp_q.size() < DEPTH);
    pend     = '{{st_addr[31:2], 2'b00}, st_data};
    if (!rst && drain_req && drain_ack) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL drain_unexpected: got addr 0x%0h expected no drain", drain_addr);
      end else begin
        e = exp_q.pop_front();
        chk("sb_order_addr", drain_addr, e.addr);
        chk("sb_order_data", drain_data, e.data);
      end
    end
  end

  // One clock of stimulus; the store accepted last cycle becomes part of the model first.
  task automatic cycle(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                       input bit lv, input logic [31:0] la, input bit ack);
    @(posedge clk);
    #1;
    if (acc_pend) begin
      exp_q.push_back(pend);
      acc_pend = 1'b0;
    end
    st_valid  = sv; st_addr = sa; st_data = sd;
    ld_valid  = lv; ld_addr = la; drain_ack = ack;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 1);
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    st_valid = 0; st_addr = 0; st_data = 0;
    ld_valid = 0; ld_addr = 0; drain_ack = 0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_drain_req", 32'(drain_req), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    idle(5);

    // single store then a load to an unaligned address in the same word
    cycle(1, 32'h100, 32'hAAAA, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h102, 0);
    #1;
    chk("first_drain_req", 32'(drain_req), 32'd1);
    chk("first_drain_addr", drain_addr, 32'h100);
    chk("first_drain_data", drain_data, 32'hAAAA);
    chk("first_count", 32'(count), 32'd1);
    chk("first_hit_reserve", 32'(hit_reserve), 32'd1);
    chk("first_fwd", fwd_data, 32'hAAAA);

    // fill, youngest-first forwarding, drop when full
    cycle(1, 32'h200, 32'd1, 0, 0, 0);
    cycle(1, 32'h200, 32'd2, 0, 0, 0);
    cycle(1, 32'h300, 32'd3, 0, 0, 0);
    cycle(1, 32'h400, 32'd4, 1, 32'h200, 0);
    #1;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_fwd_youngest", fwd_data, 32'd2);
    chk("fill_not_reserve", 32'(hit_reserve), 32'd0);
    cycle(0, 0, 0, 1, 32'h400, 1);
    #1;
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_no_hit", 32'(sb_hit), 32'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    #1;
    chk("drained_empty", 32'(empty), 32'd1);
    chk("drained_req", 32'(drain_req), 32'd0);

    // simultaneous push and pop with two entries
    cycle(1, 32'h600, 32'h61, 0, 0, 0);
    cycle(1, 32'h700, 32'h71, 0, 0, 0);
    cycle(1, 32'h800, 32'h81, 0, 0, 1);
    #1;
    chk("pp_count_before", 32'(count), 32'd2);
    cycle(0, 0, 0, 1, 32'h800, 0);
    #1;
    chk("pp_count_after", 32'(count), 32'd2);
    chk("pp_head", drain_addr, 32'h700);
    chk("pp_tail_fwd", fwd_data, 32'h81);
    drain_all();

    // random traffic; upstream respects full
    for (int n = 0; n < 400; n++) begin
      automatic bit          sv = ($urandom_range(0, 99) < 55) && !full;
      automatic logic [31:0] sa = 32'h1000 + (32'($urandom_range(0, 5)) << 2);
      automatic logic [31:0] la = 32'h1000 + (32'($urandom_range(0, 6)) << 2) + 32'($urandom_range(0, 3));
      cycle(sv, sa, $urandom, $urandom_range(0, 99) < 70, la, $urandom_range(0, 99) < 45);
    end
    drain_all();

    // asynchronous reset mid-issue with three entries
    cycle(1, 32'h900, 32'h91, 0, 0, 0);
    cycle(1, 32'hA00, 32'hA1, 0, 0, 0);
    cycle(1, 32'hB00, 32'hB1, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h900, 0);
    #1;
    chk("pre_rst_hit", 32'(sb_hit), 32'd1);
    #2 rst = 1'b1;
    exp_q.delete();
    acc_pend = 1'b0;
    #1;
    chk("arst_drain_req", 32'(drain_req), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_sb_hit", 32'(sb_hit), 32'd0);
    chk("arst_drain_addr", drain_addr, 32'h0);
    chk("arst_fwd", fwd_data, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    cycle(1, 32'hC00, 32'hC1, 1, 32'hA00, 0);
    cycle(0, 0, 0, 1, 32'hC00, 1);
    #1;
    chk("post_rst_fwd", fwd_data, 32'hC1);
    drain_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
